// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one word-wide memory port between an instruction-fetch
// requester (IF) and a load/store requester (LS).
// Build option: define MEM_ARB_RR_EN to break simultaneous requests round-robin;
// left undefined, LS always wins a tie. Single-requester behaviour is the same.
// Handshake: a requester holds *_valid with stable fields; the request is taken
// in the cycle where *_valid & *_ready are both high. *_ready is combinational,
// high only in IDLE and only for the arbitration winner. Each accepted request
// produces exactly one *_rvalid pulse (with *_rdata/*_err) unless reset intervenes.
// Memory side: mem_req and all mem_* fields stay stable until a one-cycle mem_ack.
module mem_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_valid,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        ls_valid,
  input  logic [31:0] ls_addr,
  input  logic        ls_wen,
  input  logic [2:0]  ls_memop,
  input  logic [31:0] ls_wdata,
  output logic        ls_ready,
  output logic        ls_rvalid,
  output logic [31:0] ls_rdata,
  output logic        ls_err,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic        mem_wen,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic       OWN_IF  = 1'b0;
  localparam logic       OWN_LS  = 1'b1;
  // Last WAIT cycle index before giving up: TIMEOUT WAIT cycles in total.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        owner_q;
  logic [7:0]  cnt_q;
  logic [1:0]  a_off_q;
  logic        a_wen_q;
  logic [2:0]  a_memop_q;

  logic        prio_ls;
  logic        acc_if, acc_ls, accept;
  logic [31:0] req_addr;
  logic        req_wen;
  logic [2:0]  req_memop;
  logic [31:0] req_wdata;
  logic        req_err;
  logic [3:0]  req_wmask;
  logic [31:0] req_lane_data;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] rd_ext;
  logic        resp_we, resp_ls, resp_err;
  logic [31:0] resp_data;

`ifdef MEM_ARB_RR_EN
  logic rr_ls_q;
  assign prio_ls = rr_ls_q;
`else
  assign prio_ls = 1'b1;
`endif

  assign ls_ready  = (state_q == ST_IDLE) && ls_valid && (!if_valid || prio_ls);
  assign if_ready  = (state_q == ST_IDLE) && if_valid && !(ls_valid && prio_ls);
  assign acc_ls    = ls_valid && ls_ready;
  assign acc_if    = if_valid && if_ready;
  assign accept    = acc_ls || acc_if;
  assign if_rvalid = (state_q == ST_RESP) && (owner_q == OWN_IF);
  assign ls_rvalid = (state_q == ST_RESP) && (owner_q == OWN_LS);
  assign dbg_state = state_q;

  // Select the fields of the request being granted; fetch is always a word read.
  always_comb begin
    req_addr  = if_addr;
    req_wen   = 1'b0;
    req_memop = 3'b010;
    req_wdata = 32'h0;
    if (acc_ls) begin
      req_addr  = ls_addr;
      req_wen   = ls_wen;
      req_memop = ls_memop;
      req_wdata = ls_wdata;
    end
  end

  // Flag illegal memop codes and misaligned halfword/word accesses.
  always_comb begin
    req_err = 1'b0;
    case (req_memop)
      3'b000, 3'b100: req_err = 1'b0;
      3'b001, 3'b101: req_err = (req_addr[1:0] == 2'b11);
      3'b010:         req_err = (req_addr[1:0] != 2'b00);
      default:        req_err = 1'b1;
    endcase
  end

  // Place store data in its byte lanes; offset 0 is the most significant lane.
  always_comb begin
    req_wmask     = 4'b0000;
    req_lane_data = 32'h0;
    if (req_wen) begin
      case (req_memop[1:0])
        2'b00: begin
          req_wmask     = 4'b1000 >> req_addr[1:0];
          req_lane_data = {24'h0, req_wdata[7:0]} << {~req_addr[1:0], 3'b000};
        end
        2'b01: begin
          req_wmask     = 4'b1100 >> req_addr[1:0];
          req_lane_data = {16'h0, req_wdata[15:0]} << {2'd2 - req_addr[1:0], 3'b000};
        end
        default: begin
          req_wmask     = 4'b1111;
          req_lane_data = req_wdata;
        end
      endcase
    end
  end

  // Extract and extend read data according to the latched memop and offset.
  always_comb begin
    rd_byte = 8'(mem_rdata >> {~a_off_q, 3'b000});
    rd_half = 16'(mem_rdata >> {2'd2 - a_off_q, 3'b000});
    rd_ext  = 32'h0;
    case (a_memop_q)
      3'b000:  rd_ext = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  rd_ext = {{16{rd_half[15]}}, rd_half};
      3'b010:  rd_ext = mem_rdata;
      3'b100:  rd_ext = {24'h0, rd_byte};
      3'b101:  rd_ext = {16'h0, rd_half};
      default: rd_ext = 32'h0;
    endcase
  end

  // Next-state logic and the response write strobe for the owner's data/err.
  always_comb begin
    state_d   = state_q;
    resp_we   = 1'b0;
    resp_ls   = owner_q;
    resp_data = 32'h0;
    resp_err  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (req_err) begin
            state_d  = ST_RESP;
            resp_we  = 1'b1;
            resp_ls  = acc_ls;
            resp_err = 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (mem_ack) begin
          state_d   = ST_RESP;
          resp_we   = 1'b1;
          resp_data = a_wen_q ? 32'h0 : rd_ext;
        end else if (cnt_q == TO_LAST) begin
          state_d  = ST_RESP;
          resp_we  = 1'b1;
          resp_err = 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Latch the granted request, drive the memory port, run the WAIT counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q   <= OWN_IF;
      cnt_q     <= 8'd0;
      a_off_q   <= 2'b00;
      a_wen_q   <= 1'b0;
      a_memop_q <= 3'b000;
      mem_req   <= 1'b0;
      mem_addr  <= 32'h0;
      mem_wen   <= 1'b0;
      mem_wdata <= 32'h0;
      mem_wmask <= 4'b0000;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            owner_q   <= acc_ls;
            cnt_q     <= 8'd0;
            a_off_q   <= req_addr[1:0];
            a_wen_q   <= req_wen;
            a_memop_q <= req_memop;
            if (!req_err) begin
              mem_req   <= 1'b1;
              mem_addr  <= {req_addr[31:2], 2'b00};
              mem_wen   <= req_wen;
              mem_wdata <= req_lane_data;
              mem_wmask <= req_wmask;
            end
          end
        end
        ST_WAIT: begin
          if (mem_ack || cnt_q == TO_LAST) mem_req <= 1'b0;
          else                             cnt_q   <= cnt_q + 8'd1;
        end
        default: ;
      endcase
    end
  end

  // Response data/err registers; they hold their value between pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_rdata <= 32'h0;
      if_err   <= 1'b0;
      ls_rdata <= 32'h0;
      ls_err   <= 1'b0;
    end else if (resp_we) begin
      if (resp_ls) begin
        ls_rdata <= resp_data;
        ls_err   <= resp_err;
      end else begin
        if_rdata <= resp_data;
        if_err   <= resp_err;
      end
    end
  end

`ifdef MEM_ARB_RR_EN
  // Tie-break pointer: after every grant, favour the other requester.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         rr_ls_q <= 1'b1;
    else if (accept) rr_ls_q <= acc_if;
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: table of single transactions plus hand-written
// sequences for timeout, late ack, reset mid-WAIT and tie arbitration.
module tb_mem_arbiter;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_valid = 1'b0;
  logic [31:0] if_addr = 32'h0;
  logic        if_ready, if_rvalid, if_err;
  logic [31:0] if_rdata;
  logic        ls_valid = 1'b0;
  logic [31:0] ls_addr = 32'h0;
  logic        ls_wen = 1'b0;
  logic [2:0]  ls_memop = 3'b000;
  logic [31:0] ls_wdata = 32'h0;
  logic        ls_ready, ls_rvalid, ls_err;
  logic [31:0] ls_rdata;
  logic        mem_req, mem_wen;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic [1:0]  dbg_state;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  mem_arbiter #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .if_valid(if_valid), .if_addr(if_addr), .if_ready(if_ready),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
    .ls_valid(ls_valid), .ls_addr(ls_addr), .ls_wen(ls_wen),
    .ls_memop(ls_memop), .ls_wdata(ls_wdata), .ls_ready(ls_ready),
    .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata), .ls_err(ls_err),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wen(mem_wen),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  // Clock.
  always #5 clk = ~clk;

  typedef struct {
    logic        is_ls;
    logic [31:0] addr;
    logic        wen;
    logic [2:0]  memop;
    logic [31:0] wdata;
    int          ack_cycle;
    logic [31:0] mem_rd;
    logic        exp_err;
    logic [31:0] exp_addr;
    logic [3:0]  exp_wmask;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic is_ls, input logic [31:0] addr,
                              input logic wen, input logic [2:0] memop,
                              input logic [31:0] wdata, input int ack_cycle,
                              input logic [31:0] mem_rd, input logic exp_err,
                              input logic [31:0] exp_addr, input logic [3:0] exp_wmask,
                              input logic [31:0] exp_wdata, input logic [31:0] exp_rdata);
    vec_t v;
    v.is_ls = is_ls; v.addr = addr; v.wen = wen; v.memop = memop; v.wdata = wdata;
    v.ack_cycle = ack_cycle; v.mem_rd = mem_rd; v.exp_err = exp_err;
    v.exp_addr = exp_addr; v.exp_wmask = exp_wmask; v.exp_wdata = exp_wdata;
    v.exp_rdata = exp_rdata;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_b(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic drive_req(input vec_t v);
    if (v.is_ls) begin
      ls_valid = 1'b1; ls_addr = v.addr; ls_wen = v.wen;
      ls_memop = v.memop; ls_wdata = v.wdata;
    end else begin
      if_valid = 1'b1; if_addr = v.addr;
    end
  endtask

  // One complete transaction: accept, WAIT with ack on a chosen cycle, RESP.
  task automatic run_vec(input int idx, input vec_t v);
    logic [31:0] exp_rd;
    @(negedge clk);
    drive_req(v);
    #1;
    if (v.is_ls) chk_b($sformatf("v%0d_ls_ready", idx), ls_ready, 1'b1);
    else         chk_b($sformatf("v%0d_if_ready", idx), if_ready, 1'b1);
    exp_q.push_back(v.exp_rdata);
    @(negedge clk);
    if_valid = 1'b0;
    ls_valid = 1'b0;
    if (!v.exp_err) begin
      for (int k = 1; k <= v.ack_cycle; k++) begin
        chk_b($sformatf("v%0d_mem_req_c%0d", idx, k), mem_req, 1'b1);
        chk($sformatf("v%0d_mem_addr_c%0d", idx, k), mem_addr, v.exp_addr);
        chk_b($sformatf("v%0d_mem_wen_c%0d", idx, k), mem_wen, v.wen);
        chk($sformatf("v%0d_mem_wmask_c%0d", idx, k), {28'h0, mem_wmask}, {28'h0, v.exp_wmask});
        if (v.wen) chk($sformatf("v%0d_mem_wdata_c%0d", idx, k), mem_wdata, v.exp_wdata);
        if (k == v.ack_cycle) begin
          mem_ack = 1'b1;
          mem_rdata = v.mem_rd;
        end
        @(negedge clk);
      end
      mem_ack = 1'b0;
      mem_rdata = $urandom;
    end
    exp_rd = exp_q.pop_front();
    chk_b($sformatf("v%0d_resp_mem_req", idx), mem_req, 1'b0);
    if (v.is_ls) begin
      chk_b($sformatf("v%0d_ls_rvalid", idx), ls_rvalid, 1'b1);
      chk_b($sformatf("v%0d_if_rvalid", idx), if_rvalid, 1'b0);
      chk($sformatf("v%0d_ls_rdata", idx), ls_rdata, exp_rd);
      chk_b($sformatf("v%0d_ls_err", idx), ls_err, v.exp_err);
    end else begin
      chk_b($sformatf("v%0d_if_rvalid", idx), if_rvalid, 1'b1);
      chk_b($sformatf("v%0d_ls_rvalid", idx), ls_rvalid, 1'b0);
      chk($sformatf("v%0d_if_rdata", idx), if_rdata, exp_rd);
      chk_b($sformatf("v%0d_if_err", idx), if_err, v.exp_err);
    end
  endtask

  logic exp_ls[3];

  initial begin
    // is_ls addr wen memop wdata ack rd_data err exp_addr mask exp_wdata exp_rdata
    vecs.push_back(mk(0, 32'h80000004, 0, 3'b010, 32'h0,        3, 32'hDEADBEEF, 0, 32'h80000004, 4'b0000, 32'h0,        32'hDEADBEEF));
    vecs.push_back(mk(1, 32'h80000003, 0, 3'b000, 32'h0,        1, 32'h000000F0, 0, 32'h80000000, 4'b0000, 32'h0,        32'hFFFFFFF0));
    vecs.push_back(mk(1, 32'h80000003, 0, 3'b100, 32'h0,        1, 32'h000000F0, 0, 32'h80000000, 4'b0000, 32'h0,        32'h000000F0));
    vecs.push_back(mk(1, 32'h80000002, 1, 3'b001, 32'h1234ABCD, 2, 32'h55555555, 0, 32'h80000000, 4'b0011, 32'h0000ABCD, 32'h0));
    vecs.push_back(mk(1, 32'h10000001, 1, 3'b000, 32'h777777A5, 1, 32'hFFFFFFFF, 0, 32'h10000000, 4'b0100, 32'h00A50000, 32'h0));
    vecs.push_back(mk(1, 32'h20000008, 1, 3'b010, 32'hCAFEF00D, 2, 32'h12345678, 0, 32'h20000008, 4'b1111, 32'hCAFEF00D, 32'h0));
    vecs.push_back(mk(1, 32'h30000000, 0, 3'b001, 32'h0,        1, 32'h80011234, 0, 32'h30000000, 4'b0000, 32'h0,        32'hFFFF8001));
    vecs.push_back(mk(1, 32'h30000002, 0, 3'b101, 32'h0,        1, 32'h80018234, 0, 32'h30000000, 4'b0000, 32'h0,        32'h00008234));
    vecs.push_back(mk(1, 32'h30000001, 0, 3'b001, 32'h0,        1, 32'h12F00034, 0, 32'h30000000, 4'b0000, 32'h0,        32'hFFFFF000));
    vecs.push_back(mk(1, 32'h40000001, 0, 3'b100, 32'h0,        1, 32'h11223344, 0, 32'h40000000, 4'b0000, 32'h0,        32'h00000022));
    vecs.push_back(mk(1, 32'h50000000, 0, 3'b010, 32'h0,        3, 32'h0BADF00D, 0, 32'h50000000, 4'b0000, 32'h0,        32'h0BADF00D));
    vecs.push_back(mk(1, 32'h80000003, 0, 3'b001, 32'h0,        0, 32'h0,        1, 32'h0,        4'b0000, 32'h0,        32'h0));
    vecs.push_back(mk(1, 32'h80000000, 0, 3'b011, 32'h0,        0, 32'h0,        1, 32'h0,        4'b0000, 32'h0,        32'h0));
    vecs.push_back(mk(1, 32'h80000002, 0, 3'b010, 32'h0,        0, 32'h0,        1, 32'h0,        4'b0000, 32'h0,        32'h0));
    vecs.push_back(mk(0, 32'h80000002, 0, 3'b010, 32'h0,        0, 32'h0,        1, 32'h0,        4'b0000, 32'h0,        32'h0));
    vecs.push_back(mk(1, 32'h80000000, 1, 3'b110, 32'hFFFFFFFF, 0, 32'h0,        1, 32'h0,        4'b0000, 32'h0,        32'h0));
    vecs.push_back(mk(1, 32'h80000001, 1, 3'b001, 32'h0000BEEF, 1, 32'h0,        0, 32'h80000000, 4'b0110, 32'h00BEEF00, 32'h0));
    vecs.push_back(mk(0, 32'h00001000, 0, 3'b010, 32'h0,        2, 32'h13579BDF, 0, 32'h00001000, 4'b0000, 32'h0,        32'h13579BDF));
    vecs.push_back(mk(1, 32'h10000003, 1, 3'b000, 32'h0000005A, 1, 32'h0,        0, 32'h10000000, 4'b0001, 32'h0000005A, 32'h0));

`ifdef MEM_ARB_RR_EN
    exp_ls[0] = 1'b1; exp_ls[1] = 1'b0; exp_ls[2] = 1'b1;
`else
    exp_ls[0] = 1'b1; exp_ls[1] = 1'b1; exp_ls[2] = 1'b1;
`endif

    // Reset state.
    @(negedge clk);
    chk_b("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk_b("rst_if_rvalid", if_rvalid, 1'b0);
    chk_b("rst_ls_rvalid", ls_rvalid, 1'b0);
    chk("rst_dbg_state", {30'h0, dbg_state}, 32'h0);
    rst = 1'b0;

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // Timeout: no ack, mem_req held TMO cycles, then error response; late ack ignored.
    @(negedge clk);
    ls_valid = 1'b1; ls_addr = 32'h60000000; ls_wen = 1'b0; ls_memop = 3'b010;
    @(negedge clk);
    ls_valid = 1'b0;
    for (int k = 1; k <= TMO; k++) begin
      chk_b($sformatf("tmo_mem_req_c%0d", k), mem_req, 1'b1);
      @(negedge clk);
    end
    chk_b("tmo_mem_req_drop", mem_req, 1'b0);
    chk_b("tmo_ls_rvalid", ls_rvalid, 1'b1);
    chk_b("tmo_ls_err", ls_err, 1'b1);
    chk("tmo_ls_rdata", ls_rdata, 32'h0);
    mem_ack = 1'b1;
    mem_rdata = 32'hFFFF0000;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk_b($sformatf("late_ack_rvalid_%0d", k), ls_rvalid, 1'b0);
      chk_b($sformatf("late_ack_mem_req_%0d", k), mem_req, 1'b0);
      chk_b($sformatf("late_ack_err_hold_%0d", k), ls_err, 1'b1);
      chk($sformatf("late_ack_state_%0d", k), {30'h0, dbg_state}, 32'h0);
    end
    mem_ack = 1'b0;

    run_vec(100, mk(1, 32'h60000004, 0, 3'b010, 32'h0, 1, 32'h2468ACE0, 0,
                    32'h60000004, 4'b0000, 32'h0, 32'h2468ACE0));

    // Reset asserted mid-WAIT clears everything without a clock edge.
    @(negedge clk);
    if_valid = 1'b1; if_addr = 32'h70000000;
    @(negedge clk);
    if_valid = 1'b0;
    chk_b("rstw_mem_req_before", mem_req, 1'b1);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk_b("rstw_mem_req", mem_req, 1'b0);
    chk("rstw_mem_addr", mem_addr, 32'h0);
    chk_b("rstw_mem_wen", mem_wen, 1'b0);
    chk("rstw_mem_wdata", mem_wdata, 32'h0);
    chk("rstw_mem_wmask", {28'h0, mem_wmask}, 32'h0);
    chk_b("rstw_if_rvalid", if_rvalid, 1'b0);
    chk_b("rstw_ls_rvalid", ls_rvalid, 1'b0);
    chk_b("rstw_if_err", if_err, 1'b0);
    chk_b("rstw_ls_err", ls_err, 1'b0);
    chk("rstw_if_rdata", if_rdata, 32'h0);
    chk("rstw_ls_rdata", ls_rdata, 32'h0);
    chk("rstw_dbg_state", {30'h0, dbg_state}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    mem_ack = 1'b1;
    mem_rdata = 32'hA5A5A5A5;
    @(negedge clk);
    chk_b("rstw_ack_if_rvalid", if_rvalid, 1'b0);
    chk_b("rstw_ack_mem_req", mem_req, 1'b0);
    chk("rstw_ack_if_rdata", if_rdata, 32'h0);
    mem_ack = 1'b0;

    // Both requesters held valid across three consecutive grants.
    if_valid = 1'b1; if_addr = 32'h00002000;
    ls_valid = 1'b1; ls_addr = 32'h90000000; ls_wen = 1'b0; ls_memop = 3'b010;
    for (int n = 0; n < 3; n++) begin
      #1;
      chk_b($sformatf("arb%0d_ls_ready", n), ls_ready, exp_ls[n]);
      chk_b($sformatf("arb%0d_if_ready", n), if_ready, !exp_ls[n]);
      @(negedge clk);
      chk_b($sformatf("arb%0d_wait_ls_ready", n), ls_ready, 1'b0);
      chk_b($sformatf("arb%0d_wait_if_ready", n), if_ready, 1'b0);
      chk($sformatf("arb%0d_mem_addr", n), mem_addr, exp_ls[n] ? 32'h90000000 : 32'h00002000);
      mem_ack = 1'b1;
      mem_rdata = 32'h100 + n;
      @(negedge clk);
      mem_ack = 1'b0;
      chk_b($sformatf("arb%0d_ls_rvalid", n), ls_rvalid, exp_ls[n]);
      chk_b($sformatf("arb%0d_if_rvalid", n), if_rvalid, !exp_ls[n]);
      @(negedge clk);
    end
    if_valid = 1'b0;
    ls_valid = 1'b0;

    // Final report.
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255: cycles in WAIT before an error response; 8-bit counter; TIMEOUT >= 1.
REQ-002 clk  in  1  sole clock, all state updates on posedge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 if_valid in 1 / if_addr in 32: instruction-fetch word read request.
REQ-005 if_ready out 1 / if_rvalid out 1 / if_rdata out 32 / if_err out 1: fetch accept, response pulse, data, error.
REQ-006 ls_valid in 1 / ls_addr in 32 / ls_wen in 1 / ls_memop in 3 / ls_wdata in 32: load-store request.
REQ-007 ls_ready out 1 / ls_rvalid out 1 / ls_rdata out 32 / ls_err out 1: LSU accept, response pulse, data, error.
REQ-008 mem_req out 1 / mem_addr out 32 / mem_wen out 1 / mem_wdata out 32 / mem_wmask out 4: shared memory port.
REQ-009 mem_ack in 1 / mem_rdata in 32: single-cycle completion pulse with word read data.

Function
REQ-010 ls_memop encoding SHALL be: 000 byte signed, 001 half signed, 010 word, 100 byte unsigned, 101 half unsigned; other codes error; fetch is always word.
REQ-011 Lane order SHALL be: offset 0 = data[31:24] = mask[3]; offset 3 = data[7:0] = mask[0].
REQ-012 FSM states SHALL be IDLE, WAIT, RESP; owner register (IF/LS) records the granted requester.
REQ-013 if_ready/ls_ready SHALL be combinational, high only in IDLE and only for the requester selected by arbitration; a request is accepted on valid & ready.
REQ-014 In IDLE with one valid: grant it; with both valid: grant LS (fixed priority, see REQ-027).
REQ-015 On accept SHALL latch address, wen, memop, wdata; next cycle WAIT with mem_req=1, mem_addr = addr & ~3.
REQ-016 Writes: byte mask 1000>>off with wdata[7:0] placed in that lane; half mask 1100>>off with wdata[15:0] placed; word mask 1111, wdata unchanged; reads drive mem_wmask=0000, mem_wen=0.
REQ-017 Misaligned accesses (half at offset 3, word/fetch at offset != 0) or illegal memop SHALL go IDLE->RESP with err=1, rdata=0, mem_req never asserted.
REQ-018 mem_req and all mem_* outputs SHALL be held stable throughout WAIT until mem_ack.
REQ-019 mem_ack in WAIT: capture mem_rdata, extract and sign/zero-extend per latched memop and offset, go RESP; mem_req deasserts in the cycle after ack.
REQ-020 RESP SHALL last exactly one cycle: owner's rvalid=1 with rdata/err; writes pulse rvalid with rdata=0; then IDLE.
REQ-021 Latency: accept cycle N, mem_req first high N+1, ack in cycle M, rvalid in M+1, next accept earliest M+2.
REQ-022 WAIT counter clears on entry, increments each cycle without ack; at TIMEOUT SHALL drop mem_req, go RESP with err=1.
REQ-023 mem_ack outside WAIT SHALL be ignored.
REQ-024 Non-owner rvalid SHALL stay 0; rdata/err hold last values between pulses.

Reset
REQ-025 rst high SHALL immediately force IDLE, owner=IF, counter=0, mem_req=0, mem_wen=0, mem_wmask=0, mem_addr=0, mem_wdata=0, both rvalid=0, both err=0, both rdata=0, RR pointer=LS.
REQ-026 Reset mid-WAIT SHALL abandon the transaction with no response; a subsequent ack is ignored.

Configuration
REQ-027 MEM_ARB_RR_EN defined: simultaneous requests granted round-robin (pointer toggles to the other requester after each grant, first tie to LS after reset); undefined: LS always wins ties; single-requester behaviour identical.

Verification
REQ-028 Fetch 0x80000004, ack after 3 cycles rdata 0xDEADBEEF -> mem_req 3 cycles, if_rvalid one cycle later, if_rdata 0xDEADBEEF, if_err 0.
REQ-029 LS lb addr 0x80000003, mem_rdata 0x000000F0 -> ls_rdata 0xFFFFFFF0; same with memop 100 -> 0x000000F0.
REQ-030 LS sh addr 0x80000002 wdata 0x1234ABCD -> mem_addr 0x80000000, mem_wdata 0x0000ABCD, mem_wmask 0011, ls_rvalid pulse after ack.
REQ-031 LS lh addr 0x80000003 -> no mem_req, ls_rvalid + ls_err next cycle; memop 011 likewise errors.
REQ-032 No ack for TIMEOUT=4 -> mem_req drops after 4 WAIT cycles, err response; late ack ignored; rst asserted mid-WAIT -> all outputs zero same cycle.
REQ-033 Both valid 3 consecutive accepts -> without macro LS,LS,LS; with MEM_ARB_RR_EN LS,IF,LS.
